capture_ctrl: RTL and testbench

- Acquisition sequencer for the scope's 1024x9 dual-port sample buffer. Drives the buffer write port (wraddr/wrdata/we) from the ADC sample stream.
- Performs level/slope triggering with pre-trigger history. Freezes the captured record while the VGA renderer reads it, then re-arms.
- Exports the record start address so the display can read samples in time order: rdaddr = (start_addr + x) mod DEPTH.

---
 rtl/scope_pkg.sv | 32 +++
 rtl/capture_ctrl_trig_detect.sv | 39 +++
 rtl/capture_ctrl.sv | 144 ++++++++++++++
 tb/tb_capture_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared scope definitions: acquisition state encoding, default widths and
// circular-buffer address arithmetic used by both capture and display paths.
package scope_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // Both operands must already lie in 0..depth-1, so one conditional subtract
  // replaces a true modulo.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned depth);
    int unsigned s;
    s = a + b;
    return (s >= depth) ? s - depth : s;
  endfunction

  function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned depth);
    int unsigned s;
    s = a + depth - b;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/capture_ctrl_trig_detect.sv
// Slope/level trigger detector: remembers the previous accepted sample and
// flags the accepted sample that crosses the threshold in the chosen direction.
module trig_detect
  import scope_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  output logic              hit
);

  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              rise;
  logic              fall;

  always_ff @(posedge clk) begin
    if (rst)      prev_valid <= 1'b0;
    else if (clr) prev_valid <= 1'b0;
    else if (en)  prev_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en) prev <= sample;
  end

  always_comb begin
    rise = (prev < trig_level) && (sample >= trig_level);
    fall = (prev > trig_level) && (sample <= trig_level);
    hit  = en && prev_valid && (trig_falling ? fall : rise);
  end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: writes ADC samples into the circular sample buffer,
// triggers with pre-trigger history, and freezes the record for display.
module capture_ctrl
  import scope_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 640,
  parameter int PRETRIG = 64,
  parameter int AUTO_TO = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  input  logic              auto_mode,
  input  logic              run,
  input  logic              arm,
  input  logic              stop,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] wraddr,
  output logic [DATA_W-1:0] wrdata,
  output logic              we,
  output logic [ADDR_W-1:0] start_addr,
  output logic              triggered,
  output logic              forced,
  output logic [2:0]        state
);

  localparam int CNT_W    = ADDR_W + 1;
  localparam int TO_W     = (AUTO_TO > 2) ? $clog2(AUTO_TO) : 1;
  localparam int POST_LEN = DEPTH - PRETRIG;

  state_t            st, st_nx;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  pre_cnt, post_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              accept, hit, auto_hit, fire, init;
  logic              to_sat, last_pre, last_post;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  assign accept    = sample_valid && !stop &&
                     (st == ST_PREFILL || st == ST_ARMED || st == ST_POST);
  assign to_sat    = (to_cnt == TO_W'(AUTO_TO - 1));
  assign auto_hit  = accept && (st == ST_ARMED) && auto_mode && to_sat;
  assign fire      = (st == ST_ARMED) && (hit || auto_hit);
  assign last_pre  = (pre_cnt == CNT_W'(PRETRIG - 1));
  assign last_post = (post_cnt == CNT_W'(POST_LEN - 1));

  trig_detect #(.DATA_W(DATA_W)) u_trig (
    .clk          (clk),
    .rst          (rst),
    .clr          (init),
    .en           (accept),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .hit          (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    init  = 1'b0;
    if (stop) begin
      st_nx = ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:    if (arm) begin st_nx = ST_PREFILL; init = 1'b1; end
        ST_PREFILL: if (accept && last_pre) st_nx = ST_ARMED;
        ST_ARMED:   if (fire) st_nx = (POST_LEN == 1) ? ST_HOLD : ST_POST;
        ST_POST:    if (accept && last_post) st_nx = ST_HOLD;
        ST_HOLD:    if (frame_done) begin
                      st_nx = run ? ST_PREFILL : ST_IDLE;
                      init  = run;
                    end
        default:    st_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      ptr      <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      to_cnt   <= '0;
    end else if (accept) begin
      ptr <= ADDR_W'(mod_add(32'(ptr), 32'd1, DEPTH));
      if (st == ST_PREFILL) pre_cnt <= pre_cnt + 1'b1;
      if (st == ST_POST)    post_cnt <= post_cnt + 1'b1;
      if (st == ST_ARMED) begin
        if (fire) begin
          post_cnt <= CNT_W'(1);
          to_cnt   <= '0;
        end else if (!to_sat) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered buffer write port and trigger status
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      start_addr <= '0;
      triggered  <= 1'b0;
      forced     <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= ptr;
        data_p1 <= sample;
      end
      if (init) begin
        triggered <= 1'b0;
        forced    <= 1'b0;
      end else if (fire) begin
        triggered  <= 1'b1;
        forced     <= auto_hit;
        start_addr <= ADDR_W'(mod_sub(32'(ptr), PRETRIG, DEPTH));
      end else if (st == ST_HOLD && st_nx != ST_HOLD) begin
        triggered <= 1'b0;
      end
    end
  end

  assign we     = vld_p1;
  assign wraddr = addr_p1;
  assign wrdata = data_p1;
  assign state  = st;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: trigger truth table, directed acquisition sequences
// and randomized acquisitions checked against a sample-history model.
module tb_capture_ctrl;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 9;
  localparam int DEPTH   = 640;
  localparam int PRETRIG = 64;
  localparam int AUTO_TO = 16;

  logic              clk = 1'b0;
  logic              rst, sample_valid, trig_falling, auto_mode, run, arm, stop, frame_done;
  logic [DATA_W-1:0] sample, trig_level;
  logic [ADDR_W-1:0] wraddr, start_addr;
  logic [DATA_W-1:0] wrdata;
  logic              we, triggered, forced;
  logic [2:0]        state;

  always #5 clk = ~clk;

  capture_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PRETRIG(PRETRIG), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .trig_level(trig_level), .trig_falling(trig_falling), .auto_mode(auto_mode),
    .run(run), .arm(arm), .stop(stop), .frame_done(frame_done),
    .wraddr(wraddr), .wrdata(wrdata), .we(we), .start_addr(start_addr),
    .triggered(triggered), .forced(forced), .state(state)
  );

  int checks = 0;
  int errors = 0;
  int wa[$];
  int wd[$];
  int hist[$];
  int mem [1 << ADDR_W];

  // Write-port log and shadow buffer
  always @(negedge clk) begin
    if (we) begin
      wa.push_back(int'(wraddr));
      wd.push_back(int'(wrdata));
      mem[wraddr] = int'(wrdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    sample_valid = 1'b1;
    sample       = DATA_W'(s);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_arm();   arm = 1'b1;        step(); arm = 1'b0;        endtask
  task automatic pulse_stop();  stop = 1'b1;       step(); stop = 1'b0;       endtask
  task automatic pulse_frame(); frame_done = 1'b1; step(); frame_done = 1'b0; endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  // Ramp value at sample index i is (i + offset) mod 512; gap idle cycles precede each sample.
  task automatic feed_ramp(input int offset, input int gap, output int n);
    n = 0;
    while (state != 3'd4 && n < 3000) begin
      repeat (gap) step();
      send((n + offset) % 512);
      n++;
    end
  endtask

  function automatic int ramp_rec_errs(input int sa, input int first);
    int e = 0;
    for (int x = 0; x < DEPTH; x++)
      if (mem[(sa + x) % DEPTH] != (first + x) % 512) e++;
    return e;
  endfunction

  function automatic int addr_seq_errs();
    int e = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != i % DEPTH) e++;
    return e;
  endfunction

  typedef struct {
    bit falling;
    int level;
    int prev_v;
    int cur_v;
    int exp_state;
  } tvec_t;

  tvec_t tv[11];

  initial begin
    int n, e, k, i, a, s, guard, sa;
    bit trig, done, efor, slope, autoh;

    tv[0]  = '{1'b0, 256, 255, 256, 3};
    tv[1]  = '{1'b0, 256, 255, 255, 2};
    tv[2]  = '{1'b0, 256, 256, 300, 2};
    tv[3]  = '{1'b0, 256, 100, 511, 3};
    tv[4]  = '{1'b0, 256, 300, 100, 2};
    tv[5]  = '{1'b1, 256, 257, 256, 3};
    tv[6]  = '{1'b1, 256, 256,   0, 2};
    tv[7]  = '{1'b1, 256, 400, 300, 2};
    tv[8]  = '{1'b1, 256, 511,   0, 3};
    tv[9]  = '{1'b0,   0,   0,   5, 2};
    tv[10] = '{1'b1, 511, 511,   0, 2};

    rst = 1'b1; sample_valid = 1'b0; sample = '0; trig_level = '0; trig_falling = 1'b0;
    auto_mode = 1'b0; run = 1'b0; arm = 1'b0; stop = 1'b0; frame_done = 1'b0;
    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_wraddr", int'(wraddr), 0);
    chk("rst_start", int'(start_addr), 0);
    chk("rst_trig", int'(triggered), 0);
    chk("rst_forced", int'(forced), 0);
    rst = 1'b0;
    step();

    // Trigger truth table: prefill with prev_v, then one ARMED sample cur_v
    for (int t = 0; t < 11; t++) begin
      trig_falling = tv[t].falling;
      trig_level   = DATA_W'(tv[t].level);
      pulse_arm();
      repeat (PRETRIG) send(tv[t].prev_v);
      send(tv[t].cur_v);
      chk($sformatf("tvec%0d_state", t), int'(state), tv[t].exp_state);
      pulse_stop();
    end

    // Rising ramp, single shot
    trig_falling = 1'b0; trig_level = 9'd256;
    clear_log();
    pulse_arm();
    feed_ramp(0, 0, n);
    chk("ramp_state", int'(state), 4);
    chk("ramp_start", int'(start_addr), 192);
    chk("ramp_trig", int'(triggered), 1);
    chk("ramp_forced", int'(forced), 0);
    chk("ramp_samples", n, 832);
    step();
    chk("ramp_we_hold", int'(we), 0);
    chk("ramp_writes", wa.size(), 832);
    chk("ramp_trig_addr", wa[256] * 1000 + wd[256], 256 * 1000 + 256);
    chk("ramp_record", ramp_rec_errs(192, 192), 0);
    chk("ramp_addr_seq", addr_seq_errs(), 0);
    pulse_frame();
    chk("ramp_idle", int'(state), 0);

    // Falling edge after pointer wrap
    trig_falling = 1'b1;
    clear_log();
    pulse_arm();
    repeat (670) send(400);
    chk("fall_armed", int'(state), 2);
    send(100);
    chk("fall_post", int'(state), 3);
    chk("fall_start", int'(start_addr), 606);
    n = 0;
    while (state != 3'd4 && n < 1000) begin send(100); n++; end
    chk("fall_post_samples", n, 575);
    step();
    chk("fall_writes", wa.size(), 1246);
    e = 0;
    for (int x = 0; x < DEPTH; x++)
      if (mem[(606 + x) % DEPTH] != ((x < PRETRIG) ? 400 : 100)) e++;
    chk("fall_record", e, 0);
    pulse_frame();
    chk("fall_idle", int'(state), 0);

    // Auto trigger on the 16th ARMED sample
    trig_falling = 1'b0; trig_level = 9'd256; auto_mode = 1'b1;
    pulse_arm();
    repeat (PRETRIG + AUTO_TO - 1) send(10);
    chk("auto_wait", int'(state), 2);
    send(10);
    chk("auto_state", int'(state), 3);
    chk("auto_forced", int'(forced), 1);
    chk("auto_trig", int'(triggered), 1);
    chk("auto_start", int'(start_addr), 15);
    pulse_stop();
    auto_mode = 1'b0;
    pulse_arm();
    repeat (PRETRIG + 200) send(10);
    chk("noauto_state", int'(state), 2);
    chk("noauto_trig", int'(triggered), 0);
    pulse_stop();
    chk("noauto_stop", int'(state), 0);

    // Continuous re-arm
    run = 1'b1;
    clear_log();
    pulse_arm();
    feed_ramp(0, 0, n);
    chk("cont1_start", int'(start_addr), 192);
    pulse_frame();
    chk("cont_prefill", int'(state), 1);
    for (int j = 0; j < 100; j++) send((j + 100) % 512);
    chk("cont_held", int'(start_addr), 192);
    for (int j = 100; j < 160; j++) send((j + 100) % 512);
    chk("cont2_post", int'(state), 3);
    pulse_frame();
    chk("fd_in_post", int'(state), 3);
    n = 160;
    while (state != 3'd4 && n < 3000) begin send((n + 100) % 512); n++; end
    chk("cont2_samples", n, 732);
    chk("cont2_start", int'(start_addr), 92);
    step();
    chk("cont2_record", ramp_rec_errs(92, 192), 0);
    pulse_frame();
    chk("cont2_rearm", int'(state), 1);
    pulse_stop();
    run = 1'b0;

    // Stop mid-POST with a sample in the stop cycle
    clear_log();
    pulse_arm();
    n = 0;
    while (state != 3'd3 && n < 1000) begin send(n % 512); n++; end
    repeat (10) begin send(n % 512); n++; end
    stop = 1'b1; sample_valid = 1'b1; sample = 9'd5;
    step();
    stop = 1'b0; sample_valid = 1'b0;
    chk("stop_state", int'(state), 0);
    chk("stop_we", int'(we), 0);
    repeat (5) send(7);
    chk("stop_writes", wa.size(), n);
    chk("stop_start_held", int'(start_addr), 192);

    // arm and stop together in IDLE
    arm = 1'b1; stop = 1'b1;
    step();
    arm = 1'b0; stop = 1'b0;
    chk("armstop_state", int'(state), 0);
    repeat (3) send(300);
    chk("armstop_writes", wa.size(), n);

    // Sparse input, one sample in three cycles
    clear_log();
    pulse_arm();
    feed_ramp(0, 2, n);
    chk("gap_samples", n, 832);
    chk("gap_start", int'(start_addr), 192);
    step();
    chk("gap_writes", wa.size(), 832);
    chk("gap_addr_seq", addr_seq_errs(), 0);
    chk("gap_record", ramp_rec_errs(192, 192), 0);
    pulse_frame();

    // Randomized acquisitions against the sample-history model
    for (int r = 0; r < 6; r++) begin
      trig_falling = 1'($urandom_range(0, 1));
      trig_level   = DATA_W'($urandom_range(1, 510));
      auto_mode    = 1'(r % 2);
      hist.delete();
      clear_log();
      trig = 1'b0; done = 1'b0; efor = 1'b0; k = 0; guard = 0;
      pulse_arm();
      while (!done && hist.size() < 3000 && guard < 10000) begin
        guard++;
        if ($urandom_range(0, 2) != 0) begin
          s = int'($urandom_range(0, 511));
          i = hist.size();
          hist.push_back(s);
          if (i >= PRETRIG && !trig) begin
            a     = i - PRETRIG + 1;
            slope = trig_falling ? (hist[i-1] > int'(trig_level) && s <= int'(trig_level))
                                 : (hist[i-1] < int'(trig_level) && s >= int'(trig_level));
            autoh = auto_mode && (a == AUTO_TO);
            if (slope || autoh) begin trig = 1'b1; k = i; efor = autoh; end
          end
          if (trig && i == k + DEPTH - PRETRIG - 1) done = 1'b1;
          send(s);
        end else begin
          step();
        end
      end
      step();
      step();
      if (done) begin
        sa = (k - PRETRIG) % DEPTH;
        chk($sformatf("rnd%0d_state", r), int'(state), 4);
        chk($sformatf("rnd%0d_start", r), int'(start_addr), sa);
        chk($sformatf("rnd%0d_forced", r), int'(forced), int'(efor));
        chk($sformatf("rnd%0d_trig", r), int'(triggered), 1);
        chk($sformatf("rnd%0d_writes", r), wa.size(), hist.size());
        e = 0;
        for (int w = 0; w < wa.size() && w < hist.size(); w++)
          if (wa[w] != w % DEPTH || wd[w] != hist[w]) e++;
        chk($sformatf("rnd%0d_wrseq", r), e, 0);
        e = 0;
        for (int x = 0; x < DEPTH; x++)
          if (mem[(sa + x) % DEPTH] != hist[k - PRETRIG + x]) e++;
        chk($sformatf("rnd%0d_record", r), e, 0);
        pulse_frame();
        chk($sformatf("rnd%0d_idle", r), int'(state), 0);
      end else begin
        chk($sformatf("rnd%0d_armed", r), int'(state), 2);
        pulse_stop();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
